// File: rtl/core_mem_pkg.sv
// Shared definitions for the core's memory-side blocks: bus width defaults,
// response-owner encoding and byte-mask width helper.
package core_mem_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   function automatic int unsigned mask_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and MEM stage: data-priority grant
// with a streak limit, combinational command drive, registered response owner.
module mem_port_arbiter
   import core_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic                        i_req,
   input  logic [ADDR_W-1:0]           i_addr,
   output logic                        i_gnt,
   output logic                        i_rvalid,
   output logic [DATA_W-1:0]           i_rdata,

   input  logic                        d_req,
   input  logic                        d_we,
   input  logic [ADDR_W-1:0]           d_addr,
   input  logic [DATA_W-1:0]           d_wdata,
   input  logic [mask_w(DATA_W)-1:0]   d_mask,
   output logic                        d_gnt,
   output logic                        d_rvalid,
   output logic [DATA_W-1:0]           d_rdata,

   output logic                        m_en,
   output logic                        m_we,
   output logic [ADDR_W-1:0]           m_addr,
   output logic [DATA_W-1:0]           m_wdata,
   output logic [mask_w(DATA_W)-1:0]   m_mask,
   input  logic [DATA_W-1:0]           m_rdata
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   owner_e     owner, owner_next;
   logic [3:0] streak, streak_next;
   logic       d_win, i_win;

   // Raw decision feeds the state; port-visible grants are also gated by reset.
   always_comb begin
      d_win = d_req && (!i_req || (streak < STREAK_MAX));
      i_win = i_req && !d_win;
      d_gnt = rst_n && d_win;
      i_gnt = rst_n && i_win;
   end

   always_comb begin
      m_en    = i_gnt || d_gnt;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_mask  = '0;
      if (d_gnt) begin
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_mask  = d_we ? d_mask : '0;
      end else if (i_gnt) begin
         m_addr  = i_addr;
      end
   end

   always_comb begin
      owner_next = OWN_NONE;
      if (d_win) begin
         owner_next = OWN_DATA;
      end else if (i_win) begin
         owner_next = OWN_INST;
      end
   end

   always_comb begin
      streak_next = streak;
      if (i_win || !i_req) begin
         streak_next = '0;
      end else if (d_win && (streak < STREAK_MAX)) begin
         streak_next = streak + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner  <= OWN_NONE;
         streak <= '0;
      end else begin
         owner  <= owner_next;
         streak <= streak_next;
      end
   end

   assign i_rvalid = (owner == OWN_INST);
   assign d_rvalid = (owner == OWN_DATA);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule
